// File: rtl/spi_ram.sv
// Command-decoding single-port RAM fed by the SPI slave: address load, write, and read with
// auto-incrementing pointers. All outputs are registered; memory is not reset.
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       cmd_err
);

    typedef enum logic {
        NoAddr,
        AddrSet
    } addr_state_e;

    localparam logic [ADDR_SIZE-1:0] LastAddr = ADDR_SIZE'(MEM_DEPTH - 1);

    localparam logic [1:0] CmdWrAddr = 2'b00;
    localparam logic [1:0] CmdWrData = 2'b01;
    localparam logic [1:0] CmdRdAddr = 2'b10;
    localparam logic [1:0] CmdRdData = 2'b11;

    logic [7:0]           mem [MEM_DEPTH];
    addr_state_e          wr_state;
    addr_state_e          rd_state;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [ADDR_SIZE-1:0] ld_addr;
    logic                 ld_in_range;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 mem_we;

    assign ld_addr     = din[ADDR_SIZE-1:0];
    assign ld_in_range = (ld_addr <= LastAddr);
    assign wr_ok       = (wr_state == AddrSet);
    assign rd_ok       = (rd_state == AddrSet);
    assign mem_we      = rx_valid && (din[9:8] == CmdWrData) && wr_ok;

    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        return (a == LastAddr) ? '0 : a + 1'b1;
    endfunction

    // Storage has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= din[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= NoAddr;
            rd_state <= NoAddr;
            wr_addr  <= '0;
            rd_addr  <= '0;
            dout     <= '0;
            tx_valid <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            if (rx_valid) begin
                // Any accepted command drops tx_valid unless it is a successful read.
                tx_valid <= 1'b0;
                unique case (din[9:8])
                    CmdWrAddr: begin
                        if (ld_in_range) begin
                            wr_addr  <= ld_addr;
                            wr_state <= AddrSet;
                        end else begin
                            wr_state <= NoAddr;
                            cmd_err  <= 1'b1;
                        end
                    end
                    CmdWrData: begin
                        if (wr_ok) begin
                            wr_addr <= next_addr(wr_addr);
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                    CmdRdAddr: begin
                        if (ld_in_range) begin
                            rd_addr  <= ld_addr;
                            rd_state <= AddrSet;
                        end else begin
                            rd_state <= NoAddr;
                            cmd_err  <= 1'b1;
                        end
                    end
                    CmdRdData: begin
                        if (rd_ok) begin
                            dout     <= mem[rd_addr];
                            tx_valid <= 1'b1;
                            rd_addr  <= next_addr(rd_addr);
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram.sv
// Directed bench for spi_ram: vector table for the command stream plus hand-written reset and
// MEM_DEPTH=200 range/wrap sequences.
module tb_spi_ram;

    typedef struct {
        logic       rx;
        logic [9:0] din;
        logic [7:0] dout;
        logic       tx;
        logic       err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] dout;
    logic       tx_valid;
    logic       cmd_err;
    logic [7:0] dout_s;
    logic       tx_valid_s;
    logic       cmd_err_s;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid),
        .cmd_err  (cmd_err)
    );

    spi_ram #(.MEM_DEPTH(200), .ADDR_SIZE(8)) dut_s (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout_s),
        .tx_valid (tx_valid_s),
        .cmd_err  (cmd_err_s)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rx, input logic [9:0] d, input logic [7:0] o,
                       input logic tx, input logic err);
        vec_t v;
        v.rx = rx; v.din = d; v.dout = o; v.tx = tx; v.err = err;
        vecs.push_back(v);
    endtask

    // Drive one cycle at the falling edge, sample 1 ns after the rising edge.
    task automatic cmd(input logic rx, input logic [9:0] d);
        @(negedge clk);
        rx_valid = rx;
        din      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string n, input logic [7:0] o, input logic tx, input logic e);
        check({n, " dout"}, dout, o);
        check({n, " tx_valid"}, {7'b0, tx_valid}, {7'b0, tx});
        check({n, " cmd_err"}, {7'b0, cmd_err}, {7'b0, e});
    endtask

    task automatic chk_small(input string n, input logic [7:0] o, input logic tx, input logic e);
        check({n, " dout"}, dout_s, o);
        check({n, " tx_valid"}, {7'b0, tx_valid_s}, {7'b0, tx});
        check({n, " cmd_err"}, {7'b0, cmd_err_s}, {7'b0, e});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk_main("reset", 8'h00, 1'b0, 1'b0);
        chk_small("reset200", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        //  rx    din      dout   tx    err
        add(1'b1, 10'h1AA, 8'h00, 1'b0, 1'b1); // write data before address
        add(1'b0, 10'h000, 8'h00, 1'b0, 1'b0);
        add(1'b1, 10'h010, 8'h00, 1'b0, 1'b0);
        add(1'b1, 10'h13C, 8'h00, 1'b0, 1'b0);
        add(1'b1, 10'h15A, 8'h00, 1'b0, 1'b0);
        add(1'b1, 10'h210, 8'h00, 1'b0, 1'b0);
        add(1'b1, 10'h300, 8'h3C, 1'b1, 1'b0);
        add(1'b1, 10'h3FF, 8'h5A, 1'b1, 1'b0); // payload ignored on read data
        add(1'b0, 10'h000, 8'h5A, 1'b1, 1'b0); // tx_valid persists while idle
        add(1'b0, 10'h355, 8'h5A, 1'b1, 1'b0); // din ignored without rx_valid
        add(1'b1, 10'h0FF, 8'h5A, 1'b0, 1'b0);
        add(1'b1, 10'h111, 8'h5A, 1'b0, 1'b0);
        add(1'b1, 10'h122, 8'h5A, 1'b0, 1'b0); // lands at 0 after wrap
        add(1'b1, 10'h2FF, 8'h5A, 1'b0, 1'b0);
        add(1'b1, 10'h300, 8'h11, 1'b1, 1'b0);
        add(1'b1, 10'h300, 8'h22, 1'b1, 1'b0);
        add(1'b1, 10'h005, 8'h22, 1'b0, 1'b0);
        add(1'b1, 10'h177, 8'h22, 1'b0, 1'b0);
        add(1'b1, 10'h205, 8'h22, 1'b0, 1'b0);
        add(1'b1, 10'h300, 8'h77, 1'b1, 1'b0);
        add(1'b1, 10'h000, 8'h77, 1'b0, 1'b0); // address cmd drops tx_valid, dout holds

        #1;
        chk_main("por", 8'h00, 1'b0, 1'b0);
        do_reset();

        foreach (vecs[i]) begin
            cmd(vecs[i].rx, vecs[i].din);
            chk_main($sformatf("vec%0d", i), vecs[i].dout, vecs[i].tx, vecs[i].err);
        end

        // Reset asserted mid-burst clears outputs immediately; memory survives.
        cmd(1'b1, 10'h210);
        cmd(1'b1, 10'h300);
        chk_main("burst rd", 8'h3C, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_main("async rst", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cmd(1'b1, 10'h300);
        chk_main("rd no addr", 8'h00, 1'b0, 1'b1);
        cmd(1'b1, 10'h1AB);
        chk_main("wr no addr", 8'h00, 1'b0, 1'b1);
        cmd(1'b0, 10'h000);
        chk_main("err idle", 8'h00, 1'b0, 1'b0);
        cmd(1'b1, 10'h210);
        cmd(1'b1, 10'h300);
        chk_main("kept 10", 8'h3C, 1'b1, 1'b0);
        cmd(1'b1, 10'h300);
        chk_main("kept 11", 8'h5A, 1'b1, 1'b0);
        cmd(1'b1, 10'h205);
        cmd(1'b1, 10'h300);
        chk_main("kept 05", 8'h77, 1'b1, 1'b0);

        // MEM_DEPTH=200 instance: range rejection and wrap at 199.
        do_reset();
        cmd(1'b1, 10'h0C8);
        chk_small("wa c8", 8'h00, 1'b0, 1'b1);
        cmd(1'b1, 10'h1AB);
        chk_small("wd rej", 8'h00, 1'b0, 1'b1);
        cmd(1'b1, 10'h2C8);
        chk_small("ra c8", 8'h00, 1'b0, 1'b1);
        cmd(1'b1, 10'h0C7);
        chk_small("wa c7", 8'h00, 1'b0, 1'b0);
        cmd(1'b1, 10'h144);
        cmd(1'b1, 10'h155);
        chk_small("wd wrap", 8'h00, 1'b0, 1'b0);
        cmd(1'b1, 10'h2C7);
        chk_small("ra c7", 8'h00, 1'b0, 1'b0);
        cmd(1'b1, 10'h300);
        chk_small("rd c7", 8'h44, 1'b1, 1'b0);
        cmd(1'b1, 10'h300);
        chk_small("rd 0", 8'h55, 1'b1, 1'b0);
        cmd(1'b1, 10'h2FF);
        chk_small("ra ff", 8'h55, 1'b0, 1'b1);
        cmd(1'b1, 10'h300);
        chk_small("rd after rej", 8'h55, 1'b0, 1'b1);
        cmd(1'b0, 10'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
